// File: rtl/parity_pkg.sv
// Shared definitions for the multi-lane parity frame checker.
// Holds the framing FSM state encoding, parity mode codes and the lane error rule.
package parity_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // A lane is in error when its total frame parity differs from the mode:
    // even mode expects zero odd-parity, odd mode expects odd parity.
    function automatic logic lane_err(input logic par, input logic mode);
        return par ^ mode;
    endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter used for the per-lane error tallies.
// Ports: clk, rst (sync, active-high), inc, clr (wins over inc), cnt.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-lane serial parity frame checker: shared framing FSM, per-lane running
// parity, per-frame error flags and saturating per-lane error counters.
// Ports: clk, rst (sync, active-high); in_valid/x/mode_odd/resync/clear_cnt in;
//        z (running parity), frame_valid, frame_err, err_cnt (packed per lane) out.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       x,
    input  logic                      mode_odd,
    input  logic                      resync,
    input  logic                      clear_cnt,
    output logic [CHANNELS-1:0]       z,
    output logic                      frame_valid,
    output logic [CHANNELS-1:0]       frame_err,
    output logic [CHANNELS*CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FIRST_IDX = CW'(1);

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic                mode_q;
    logic [CHANNELS-1:0] p;
    logic [CHANNELS-1:0] p_next;
    logic [CHANNELS-1:0] frame_err_next;
    logic [CHANNELS-1:0] inc;
    logic                last_bit;
    logic                frame_done;

    // Parity including the bit presented this cycle.
    assign p_next = p ^ x;

    assign last_bit   = (state == ST_RECV) && (bit_cnt == LAST_IDX);
    // resync discards the final bit too, so it suppresses completion.
    assign frame_done = in_valid && !resync && last_bit;

    always_comb begin
        frame_err_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            frame_err_next[i] = lane_err(p_next[i], mode_q);
        end
    end

    assign inc = frame_done ? frame_err_next : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            mode_q      <= MODE_EVEN;
            p           <= '0;
            frame_valid <= 1'b0;
            frame_err   <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (resync) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                p       <= '0;
            end else if (in_valid) begin
                unique case (state)
                    ST_IDLE: begin
                        state   <= ST_RECV;
                        mode_q  <= mode_odd;
                        bit_cnt <= FIRST_IDX;
                        p       <= x;
                    end
                    ST_RECV: begin
                        if (last_bit) begin
                            state       <= ST_IDLE;
                            bit_cnt     <= '0;
                            p           <= '0;
                            frame_valid <= 1'b1;
                            frame_err   <= frame_err_next;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            p       <= p_next;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign z = p;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .inc(inc[i]),
            .clr(clear_cnt),
            .cnt(err_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker: directed scenarios plus a
// randomized run compared against a queue-based frame model (three configs).
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] x;
    logic       mode_odd;
    logic       resync;
    logic       clear_cnt;

    logic [3:0]  z0, z1, z2;
    logic        fv0, fv1, fv2;
    logic [3:0]  fe0, fe1, fe2;
    logic [31:0] ec0, ec2;
    logic [7:0]  ec1;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Default config.
    parity_frame_checker #(.CHANNELS(4), .FRAME_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .mode_odd(mode_odd),
        .resync(resync), .clear_cnt(clear_cnt), .z(z0), .frame_valid(fv0),
        .frame_err(fe0), .err_cnt(ec0)
    );

    // Narrow counters for saturation.
    parity_frame_checker #(.CHANNELS(4), .FRAME_LEN(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .mode_odd(mode_odd),
        .resync(resync), .clear_cnt(clear_cnt), .z(z1), .frame_valid(fv1),
        .frame_err(fe1), .err_cnt(ec1)
    );

    // Minimal frame length for back-to-back frames.
    parity_frame_checker #(.CHANNELS(4), .FRAME_LEN(2), .CNT_W(8)) u_b2b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .mode_odd(mode_odd),
        .resync(resync), .clear_cnt(clear_cnt), .z(z2), .frame_valid(fv2),
        .frame_err(fe2), .err_cnt(ec2)
    );

    logic [3:0]  o_z  [3];
    logic        o_fv [3];
    logic [3:0]  o_fe [3];
    logic [31:0] o_ec [3];

    assign o_z[0] = z0;
    assign o_z[1] = z1;
    assign o_z[2] = z2;
    assign o_fv[0] = fv0;
    assign o_fv[1] = fv1;
    assign o_fv[2] = fv2;
    assign o_fe[0] = fe0;
    assign o_fe[1] = fe1;
    assign o_fe[2] = fe2;
    assign o_ec[0] = ec0;
    assign o_ec[1] = {24'd0, ec1};
    assign o_ec[2] = ec2;

    // Reference model: a frame is the list of bit vectors accepted so far.
    int          flen [3] = '{8, 8, 2};
    int          cmax [3] = '{255, 3, 255};
    logic [3:0]  q    [3][$];
    logic        m_mode [3];
    int          m_ec [3][4];
    logic [3:0]  e_z  [3];
    logic        e_fv [3];
    logic [3:0]  e_fe [3];
    logic [31:0] e_ec [3];

    always @(posedge clk) begin : model
        int n;
        for (int k = 0; k < 3; k++) begin
            e_fv[k] = 1'b0;
            if (rst) begin
                q[k].delete();
                m_mode[k] = 1'b0;
                e_fe[k] = 4'd0;
                for (int i = 0; i < 4; i++) m_ec[k][i] = 0;
            end else begin
                if (resync) begin
                    q[k].delete();
                end else if (in_valid) begin
                    if (q[k].size() == 0) m_mode[k] = mode_odd;
                    q[k].push_back(x);
                    if (q[k].size() == flen[k]) begin
                        for (int i = 0; i < 4; i++) begin
                            n = 0;
                            for (int j = 0; j < q[k].size(); j++)
                                n += int'(q[k][j][i]);
                            e_fe[k][i] = ((n % 2) == 1) != m_mode[k];
                            if (e_fe[k][i] && m_ec[k][i] < cmax[k])
                                m_ec[k][i]++;
                        end
                        e_fv[k] = 1'b1;
                        q[k].delete();
                    end
                end
                if (clear_cnt)
                    for (int i = 0; i < 4; i++) m_ec[k][i] = 0;
            end
            e_ec[k] = 32'd0;
            for (int i = 0; i < 4; i++) begin
                n = 0;
                for (int j = 0; j < q[k].size(); j++)
                    n += int'(q[k][j][i]);
                e_z[k][i] = ((n % 2) == 1);
                if (k == 1) e_ec[k][i*2 +: 2] = 2'(m_ec[k][i]);
                else        e_ec[k][i*8 +: 8] = 8'(m_ec[k][i]);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] xv, input logic m,
                         input logic rs, input logic cc);
        in_valid  = v;
        x         = xv;
        mode_odd  = m;
        resync    = rs;
        clear_cnt = cc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                ncmp++;
                if (o_z[k] !== 4'd0 || o_fv[k] !== 1'b0 || o_ec[k] !== 32'd0) begin
                    nerr++;
                    $display("FAIL reset inst%0d: z=%h fv=%b ec=%h, want 0", k,
                             o_z[k], o_fv[k], o_ec[k]);
                end
            end
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_even_frame();
        logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic zs  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, {2'($urandom), 1'b0, seq[j]}, 1'b0, 1'b0, 1'b0);
            ncmp++;
            if (z0[0] !== zs[j]) begin
                nerr++;
                $display("FAIL even z0 bit%0d: got %b want %b", j, z0[0], zs[j]);
            end
            ncmp++;
            if (fv0 !== (j == 7)) begin
                nerr++;
                $display("FAIL even frame_valid bit%0d: got %b want %b", j, fv0, j == 7);
            end
        end
        ncmp++;
        if (fe0[0] !== 1'b0) begin
            nerr++;
            $display("FAIL even frame_err0: got %b want 0", fe0[0]);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        ncmp++;
        if (fv0 !== 1'b0) begin
            nerr++;
            $display("FAIL even pulse width: frame_valid %b want 0", fv0);
        end
    endtask

    task automatic test_odd_err();
        for (int j = 0; j < 8; j++)
            drive(1'b1, {2'($urandom), 1'b0, 1'($urandom)}, 1'b1, 1'b0, 1'b0);
        ncmp++;
        if (fv0 !== 1'b1 || fe0[1] !== 1'b1 || ec0[15:8] !== 8'd1) begin
            nerr++;
            $display("FAIL odd_err: fv=%b fe1=%b cnt1=%0d want 1 1 1",
                     fv0, fe0[1], ec0[15:8]);
        end
    endtask

    task automatic test_mode_latch();
        logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 8; j++)
            drive(1'b1, {4{seq[j]}}, (j >= 3), 1'b0, 1'b0);
        ncmp++;
        if (fv0 !== 1'b1 || fe0 !== 4'd0 || fe1 !== 4'd0) begin
            nerr++;
            $display("FAIL mode_latch: fv=%b fe=%h fe_sat=%h want 1 0 0", fv0, fe0, fe1);
        end
    endtask

    task automatic test_resync();
        int nfv = 0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
            nfv += int'(fv0);
        end
        drive(1'b1, 4'($urandom), 1'($urandom), 1'b1, 1'b0);
        nfv += int'(fv0);
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
            nfv += int'(fv0);
            ncmp++;
            if (fv0 !== (j == 7)) begin
                nerr++;
                $display("FAIL resync frame_valid bit%0d: got %b want %b", j, fv0, j == 7);
            end
            if (j == 3)
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
                    nfv += int'(fv0);
                end
        end
        ncmp++;
        if (fe0 !== e_fe[0]) begin
            nerr++;
            $display("FAIL resync frame_err: got %h want %h", fe0, e_fe[0]);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        nfv += int'(fv0);
        ncmp++;
        if (nfv != 1) begin
            nerr++;
            $display("FAIL resync pulse count: got %0d want 1", nfv);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < 8; j++)
                drive(1'b1, (j == 0) ? 4'hF : 4'h0, 1'b0, 1'b0, (f == 5 && j == 7));
            if (f == 4) begin
                ncmp++;
                if (ec1 !== 8'hFF || ec0 !== e_ec[0]) begin
                    nerr++;
                    $display("FAIL saturate: sat=%h want ff, wide=%h want %h",
                             ec1, ec0, e_ec[0]);
                end
            end
        end
        ncmp++;
        if (ec1 !== 8'h00 || ec0 !== 32'd0 || fv0 !== 1'b1 || fe0 !== 4'hF) begin
            nerr++;
            $display("FAIL clear: sat=%h wide=%h fv=%b fe=%h want 0 0 1 f",
                     ec1, ec0, fv0, fe0);
        end
    endtask

    task automatic test_back_to_back();
        int nfv = 0;
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
            nfv += int'(fv2);
            ncmp++;
            if (fv2 !== ((j % 2) == 1) || fe2 !== e_fe[2] || z2 !== e_z[2]) begin
                nerr++;
                $display("FAIL b2b cycle%0d: fv=%b fe=%h z=%h want %b %h %h", j,
                         fv2, fe2, z2, (j % 2) == 1, e_fe[2], e_z[2]);
            end
        end
        ncmp++;
        if (nfv != 10) begin
            nerr++;
            $display("FAIL b2b pulse count: got %0d want 10", nfv);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 9) < 7), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
            for (int k = 0; k < 3; k++) begin
                ncmp++;
                if (o_z[k] !== e_z[k] || o_fv[k] !== e_fv[k] ||
                    o_fe[k] !== e_fe[k] || o_ec[k] !== e_ec[k]) begin
                    nerr++;
                    $display("FAIL random c%0d inst%0d: z=%h fv=%b fe=%h ec=%h want %h %b %h %h",
                             c, k, o_z[k], o_fv[k], o_fe[k], o_ec[k],
                             e_z[k], e_fv[k], e_fe[k], e_ec[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 4'd0;
        mode_odd  = 1'b0;
        resync    = 1'b0;
        clear_cnt = 1'b0;
        test_reset();
        test_even_frame();
        test_odd_err();
        test_mode_latch();
        test_resync();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
